// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID elastic buffer: occupancy encodings,
// the NOP word and the {PC, Instr} entry record.
package if_id_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_id_buffer_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Inc_i,
    output logic [W-1:0] Cnt_o
);

    logic [W-1:0] cnt_q;

    // Count qualifying cycles, holding once the top value is reached.
    always_ff @(posedge Clk) begin
        if (Rst)
            cnt_q <= '0;
        else if (Inc_i && (cnt_q != {W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign Cnt_o = cnt_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID elastic 2-entry buffer: head register plus one skid register so a
// single cycle of ID back-pressure never drops a fetched instruction.
// Optional performance counters are built when IF_ID_PERF_EN is defined.
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int               WIDTH    = WORD_W,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_INSTR)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InPC,
    input  logic [WIDTH-1:0] InInstr,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutPC,
    output logic [WIDTH-1:0] OutInstr
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]      StallCnt,
    output logic [31:0]      FlushCnt,
    output logic [31:0]      BubbleCnt
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    buf_state_e state_q, state_d;
    entry_t     h_q, h_d;
    entry_t     s_q, s_d;
    entry_t     in_entry;
    logic       push, pop;

    // Handshake flags depend only on registered state, so OutReady never
    // reaches InReady combinationally.
    assign InReady  = (state_q != ST_FULL);
    assign OutValid = (state_q != ST_EMPTY);
    assign OutPC    = OutValid ? h_q.pc    : '0;
    assign OutInstr = OutValid ? h_q.instr : NOP_WORD;

    assign push     = InValid  & InReady;
    assign pop      = OutValid & OutReady;
    assign in_entry = '{pc: InPC, instr: InInstr};

    // Next occupancy and data; flush overrides everything except reset.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    h_d     = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    h_d = in_entry;
                end else if (push) begin
                    s_d     = in_entry;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    h_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Stale H/S contents are harmless: outputs are masked by OutValid.
        if (Flush)
            state_d = ST_EMPTY;
    end

    // Occupancy and entry registers; reset clears data as well.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_EMPTY;
            h_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end
    end

`ifdef IF_ID_PERF_EN
    sat_counter #(.W(32)) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Inc_i (InValid & ~InReady),
        .Cnt_o (StallCnt)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Inc_i (Flush & (state_q != ST_EMPTY)),
        .Cnt_o (FlushCnt)
    );

    sat_counter #(.W(32)) u_bubble_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Inc_i (~OutValid),
        .Cnt_o (BubbleCnt)
    );
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: per-cycle vector table with expected
// outputs, plus a FIFO scoreboard that checks every popped entry.
module tb_if_id_buffer;

    localparam logic [31:0] IA = 32'h2008_0005;
    localparam logic [31:0] IB = 32'h2009_0003;
    localparam logic [31:0] IC = 32'h0109_5020;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] InPC = '0;
    logic [31:0] InInstr = '0;
    logic        Flush = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutPC;
    logic [31:0] OutInstr;
`ifdef IF_ID_PERF_EN
    logic [31:0] StallCnt, FlushCnt, BubbleCnt;
`endif

    if_id_buffer dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .InPC     (InPC),
        .InInstr  (InInstr),
        .Flush    (Flush),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutPC    (OutPC),
        .OutInstr (OutInstr)
`ifdef IF_ID_PERF_EN
        ,
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt),
        .BubbleCnt (BubbleCnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic        fl;
        logic        eov;
        logic        eir;
        logic [31:0] epc;
        logic [31:0] eins;
    } vec_t;

    ent_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(logic iv, logic [31:0] pc, logic [31:0] ins,
                                logic ordy, logic fl, logic eov, logic eir,
                                logic [31:0] epc, logic [31:0] eins);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.eir = eir; v.epc = epc; v.eins = eins;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, settle, update scoreboard from the
    // handshake that is about to be taken, then step past the posedge.
    task automatic step(logic rst, logic iv, logic [31:0] pc, logic [31:0] ins,
                        logic ordy, logic fl);
        ent_t e;
        @(negedge Clk);
        Rst = rst; InValid = iv; InPC = pc; InInstr = ins;
        OutReady = ordy; Flush = fl;
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            if (OutValid && OutReady) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_underflow: popped pc %h with nothing expected", OutPC);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", OutPC, e.pc);
                    chk("sb_instr", OutInstr, e.instr);
                end
            end
            if (fl) sb.delete();
            else if (InValid && InReady) begin
                e.pc = pc; e.instr = ins;
                sb.push_back(e);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_idle(string name);
        chk({name, "_ov"}, {31'd0, OutValid}, 32'd0);
        chk({name, "_ir"}, {31'd0, InReady}, 32'd1);
        chk({name, "_pc"}, OutPC, 32'd0);
        chk({name, "_instr"}, OutInstr, 32'd0);
    endtask

    vec_t vecs[21];

    initial begin
        //            iv  pc     ins ordy fl   eov  eir  epc    eins
        vecs[0]  = mk(1, 32'd4,  IA, 1, 0,    1, 1, 32'd4,  IA);  // stream
        vecs[1]  = mk(1, 32'd8,  IB, 1, 0,    1, 1, 32'd8,  IB);
        vecs[2]  = mk(1, 32'd12, IC, 1, 0,    1, 1, 32'd12, IC);
        vecs[3]  = mk(0, 32'd0,  '0, 1, 0,    0, 1, 32'd0,  '0);
        vecs[4]  = mk(1, 32'd4,  IA, 0, 0,    1, 1, 32'd4,  IA);  // back-pressure
        vecs[5]  = mk(1, 32'd8,  IB, 0, 0,    1, 0, 32'd4,  IA);
        vecs[6]  = mk(1, 32'd12, IC, 0, 0,    1, 0, 32'd4,  IA);
        vecs[7]  = mk(1, 32'd12, IC, 1, 0,    1, 1, 32'd8,  IB);
        vecs[8]  = mk(1, 32'd12, IC, 1, 0,    1, 1, 32'd12, IC);
        vecs[9]  = mk(0, 32'd0,  '0, 1, 0,    0, 1, 32'd0,  '0);
        vecs[10] = mk(1, 32'd4,  IA, 0, 0,    1, 1, 32'd4,  IA);  // flush in FULL
        vecs[11] = mk(1, 32'd8,  IB, 0, 0,    1, 0, 32'd4,  IA);
        vecs[12] = mk(1, 32'd12, IC, 0, 1,    0, 1, 32'd0,  '0);
        vecs[13] = mk(1, 32'd4,  IA, 0, 0,    1, 1, 32'd4,  IA);  // flush drops push
        vecs[14] = mk(1, 32'd8,  IB, 0, 1,    0, 1, 32'd0,  '0);
        vecs[15] = mk(0, 32'd0,  '0, 1, 0,    0, 1, 32'd0,  '0);
        vecs[16] = mk(1, 32'd4,  IA, 0, 0,    1, 1, 32'd4,  IA);  // flush + pop
        vecs[17] = mk(0, 32'd0,  '0, 1, 1,    0, 1, 32'd0,  '0);
        vecs[18] = mk(1, 32'd4,  IA, 0, 0,    1, 1, 32'd4,  IA);  // push+pop in ONE
        vecs[19] = mk(1, 32'd8,  IB, 1, 0,    1, 1, 32'd8,  IB);
        vecs[20] = mk(0, 32'd0,  '0, 1, 0,    0, 1, 32'd0,  '0);

        // Reset held two cycles.
        step(1, 0, '0, '0, 0, 0);
        step(1, 0, '0, '0, 0, 0);
        chk_idle("reset");

        for (int i = 0; i < 21; i++) begin
            step(0, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("v%0d_ov", i), {31'd0, OutValid}, {31'd0, vecs[i].eov});
            chk($sformatf("v%0d_ir", i), {31'd0, InReady}, {31'd0, vecs[i].eir});
            chk($sformatf("v%0d_pc", i), OutPC, vecs[i].epc);
            chk($sformatf("v%0d_instr", i), OutInstr, vecs[i].eins);
        end
        chk("sb_drained", sb.size(), 32'd0);

        // Reset mid-operation while FULL: everything is lost.
        step(0, 1, 32'd4, IA, 0, 0);
        step(0, 1, 32'd8, IB, 0, 0);
        chk("pre_rst_ir", {31'd0, InReady}, 32'd0);
        step(1, 0, '0, '0, 1, 0);
        chk_idle("mid_rst");
        step(0, 0, '0, '0, 1, 0);
        chk("post_rst_ov0", {31'd0, OutValid}, 32'd0);
        step(0, 0, '0, '0, 1, 0);
        chk("post_rst_ov1", {31'd0, OutValid}, 32'd0);

`ifdef IF_ID_PERF_EN
        // Fill, stall five cycles, then flush from FULL.
        step(1, 0, '0, '0, 0, 0);
        step(0, 1, 32'd4, IA, 0, 0);
        step(0, 1, 32'd8, IB, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 32'd12, IC, 0, 0);
        step(0, 0, '0, '0, 0, 1);
        chk("perf_stall", StallCnt, 32'd5);
        chk("perf_flush", FlushCnt, 32'd1);
        chk("perf_bubble", BubbleCnt, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
